// File: rtl/pe_mac_pkg.sv
// Shared types, register map and STATUS bit positions for the PE MAC cell.
package pe_mac_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StDrain   = 2'd3
  } state_e;

  typedef enum logic {
    ModeLoad    = 1'b0,
    ModeCompute = 1'b1
  } mode_e;

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrStatus = 8'h04;
  localparam logic [7:0] AddrId     = 8'h08;
  localparam logic [7:0] AddrCnt    = 8'h0C;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlModeBit   = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;
  localparam int unsigned StatusErrBit  = 2;

endpackage

// File: rtl/pe_apb_regs.sv
// Zero-wait APB register block: CTRL start/mode, clear-on-read STATUS, ID and job counter.
module pe_apb_regs
  import pe_mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [7:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [7:0]  pe_id_i,
  input  logic        busy_i,
  input  logic        done_set_i,
  input  logic        err_set_i,
  input  logic        cnt_inc_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        start_o,
  output mode_e       mode_o
);

  logic        access;
  logic        rd_status;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q;
  logic        unused_pwdata;

  assign access    = psel_i & penable_i;
  assign pready_o  = 1'b1;
  assign start_o   = access & pwrite_i & (paddr_i == AddrCtrl) & pwdata_i[CtrlStartBit];
  assign mode_o    = mode_e'(pwdata_i[CtrlModeBit]);
  assign rd_status = access & ~pwrite_i & (paddr_i == AddrStatus);

  // A set landing in the same cycle as a clearing read wins, so no event is lost.
  assign done_d = done_set_i | (done_q & ~rd_status);
  assign err_d  = err_set_i | (err_q & ~rd_status);

  assign unused_pwdata = ^pwdata_i[31:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (cnt_inc_i) cnt_q <= cnt_q + 16'd1;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (access && !pwrite_i) begin
      case (paddr_i)
        AddrStatus: begin
          prdata_o[StatusBusyBit] = busy_i;
          prdata_o[StatusDoneBit] = done_q;
          prdata_o[StatusErrBit]  = err_q;
        end
        AddrId:  prdata_o[7:0]  = pe_id_i;
        AddrCnt: prdata_o[15:0] = cnt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_mac_cell.sv
// Weight-stationary MAC cell: loads a ROWxCOL weight tile, streams COL inputs, drains ROW sums.
// Define PE_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module pe_mac_cell
  import pe_mac_pkg::*;
#(
  parameter int unsigned WID_X   = 8,
  parameter int unsigned WID_Y   = 8,
  parameter int unsigned ROW     = 4,
  parameter int unsigned COL     = 4,
  parameter int unsigned WID_BUS = 32,
  parameter int unsigned WID_ACC = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         pe_id,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  input  logic [WID_BUS-1:0] wdata,
  input  logic               wdata_valid,
  input  logic               wdata_last,
  output logic               wdata_busy,
  output logic [WID_BUS-1:0] rdata,
  output logic               rdata_valid,
  output logic               rdata_last,
  input  logic               rdata_busy,
  output logic               pe_busy,
  output logic [1:0]         work_mode
);

  localparam int unsigned WidP    = WID_X + WID_Y;
  localparam int unsigned AccW1   = WID_ACC + 1;
  localparam int unsigned RowW    = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned ColW    = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(ROW - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COL - 1);

  state_e                    state_q, state_d;
  logic [RowW-1:0]           row_q, row_d;
  logic [ColW-1:0]           col_q, col_d;
  logic signed [WID_Y-1:0]   w_q [ROW][COL];
  logic signed [WidP-1:0]    prod_q [ROW];
  logic signed [WidP-1:0]    prod_d [ROW];
  logic                      prod_vld_q, prod_vld_d;
  logic signed [WID_ACC-1:0] acc_q [ROW];
  logic signed [WID_ACC-1:0] acc_d [ROW];
  logic signed [WID_ACC-1:0] ext;
  logic signed [AccW1-1:0]   sum;
  logic signed [WID_X-1:0]   x_in;
  logic signed [WID_Y-1:0]   w_in;
  logic                      start, xfer, out_xfer;
  logic                      w_we, clr_acc, err_set, done_set, cnt_inc;
  mode_e                     mode;
  logic                      unused_wdata;

  pe_apb_regs u_regs (
    .clk_i      (clk),
    .rst_i      (rst),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .pe_id_i    (pe_id),
    .busy_i     (pe_busy),
    .done_set_i (done_set),
    .err_set_i  (err_set),
    .cnt_inc_i  (cnt_inc),
    .prdata_o   (prdata),
    .pready_o   (pready),
    .start_o    (start),
    .mode_o     (mode)
  );

  assign x_in         = wdata[WID_X-1:0];
  assign w_in         = wdata[WID_Y-1:0];
  assign unused_wdata = ^wdata;
  assign wdata_busy   = !((state_q == StLoad) || (state_q == StCompute));
  assign xfer         = wdata_valid & ~wdata_busy;
  assign pe_busy      = (state_q != StIdle);
  assign work_mode    = state_q;

  // Results wait one extra cycle for the last registered product to land in acc.
  assign rdata_valid = (state_q == StDrain) & ~prod_vld_q;
  assign rdata_last  = rdata_valid & (row_q == RowLast);
  assign rdata       = rdata_valid ? WID_BUS'(acc_q[row_q]) : '0;
  assign out_xfer    = rdata_valid & ~rdata_busy;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    w_we       = 1'b0;
    clr_acc    = 1'b0;
    prod_vld_d = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    cnt_inc    = 1'b0;
    if (start && (state_q != StIdle)) err_set = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d = '0;
          col_d = '0;
          if (mode == ModeCompute) begin
            state_d = StCompute;
            clr_acc = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          if ((row_q == RowLast) && (col_q == ColLast)) begin
            w_we     = 1'b1;
            state_d  = StIdle;
            done_set = 1'b1;
            err_set  = ~wdata_last;
          end else if (wdata_last) begin
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            w_we = 1'b1;
            if (col_q == ColLast) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StCompute: begin
        if (xfer) begin
          if (col_q == ColLast) begin
            prod_vld_d = 1'b1;
            state_d    = StDrain;
            row_d      = '0;
            err_set    = ~wdata_last;
          end else if (wdata_last) begin
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            prod_vld_d = 1'b1;
            col_d      = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_xfer) begin
          if (row_q == RowLast) begin
            state_d  = StIdle;
            done_set = 1'b1;
            cnt_inc  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ext = '0;
    sum = '0;
    for (int r = 0; r < ROW; r++) begin
      prod_d[r] = WidP'(w_q[r][col_q]) * WidP'(x_in);
      ext       = WID_ACC'(prod_q[r]);
`ifdef PE_SAT_EN
      sum = AccW1'(acc_q[r]) + AccW1'(ext);
      if (sum[WID_ACC] != sum[WID_ACC-1]) begin
        acc_d[r] = sum[WID_ACC] ? {1'b1, {(WID_ACC-1){1'b0}}} : {1'b0, {(WID_ACC-1){1'b1}}};
      end else begin
        acc_d[r] = sum[WID_ACC-1:0];
      end
`else
      acc_d[r] = acc_q[r] + ext;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      prod_vld_q <= 1'b0;
      for (int r = 0; r < ROW; r++) begin
        prod_q[r] <= '0;
        acc_q[r]  <= '0;
        for (int c = 0; c < COL; c++) w_q[r][c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      prod_vld_q <= prod_vld_d;
      if (w_we) w_q[row_q][col_q] <= w_in;
      for (int r = 0; r < ROW; r++) begin
        if (prod_vld_d) prod_q[r] <= prod_d[r];
        if (clr_acc) acc_q[r] <= '0;
        else if (prod_vld_q) acc_q[r] <= acc_d[r];
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_cell.sv
// Self-checking bench for pe_mac_cell (WID_ACC=16) against a plain-arithmetic MAC model.
module tb_pe_mac_cell;
  import pe_mac_pkg::*;

  localparam int NR = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pe_id = 8'hA5;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;
  logic [31:0] wdata, rdata;
  logic        wdata_valid, wdata_last, wdata_busy;
  logic        rdata_valid, rdata_last, rdata_busy;
  logic        pe_busy;
  logic [1:0]  work_mode;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  typedef struct packed {
    logic [127:0] wt;   // byte 4*r+c = w[r][c]
    logic [31:0]  x;    // byte c = x[c]
    logic [127:0] exp;  // word r = acc[r], sign-extended
  } vec_t;

  vec_t tbl [10];

  pe_mac_cell #(.WID_ACC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pe_id       (pe_id),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_last  (wdata_last),
    .wdata_busy  (wdata_busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_last  (rdata_last),
    .rdata_busy  (rdata_busy),
    .pe_busy     (pe_busy),
    .work_mode   (work_mode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int fold(input int v);
`ifdef PE_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return int'(shortint'(v));
`endif
  endfunction

  function automatic logic [127:0] model(input logic [127:0] wt, input logic [31:0] x);
    logic [127:0] res;
    int acc;
    for (int r = 0; r < NR; r++) begin
      acc = 0;
      for (int c = 0; c < NC; c++)
        acc = fold(acc + int'($signed(wt[8*(NC*r+c) +: 8])) * int'($signed(x[8*c +: 8])));
      res[32*r +: 32] = acc;
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1 penable = 1;
    #1 chk(nm, prdata, exp);
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic lst);
    int n = 0;
    wdata_valid = 1; wdata = {24'($urandom), d}; wdata_last = lst;
    while (wdata_busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (wdata_busy) chk("wdata_accept_timeout", wdata_busy, 0);
    @(posedge clk); #1;
    wdata_valid = 0; wdata_last = 0;
  endtask

  task automatic load_weights(input logic [127:0] wt);
    apb_wr(AddrCtrl, 32'h1);
    chk("load_mode", work_mode, 1);
    for (int i = 0; i < NR*NC; i++) send(wt[8*i +: 8], i == NR*NC-1);
    chk("load_idle", work_mode, 0);
    rd_chk("load_status_done", AddrStatus, 32'h2);
  endtask

  task automatic latency_chk();
    chk("lat_cycle1_valid", rdata_valid, 0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", rdata_valid, 1);
  endtask

  task automatic collect(input logic [127:0] exp, input int stall_at);
    int got = 0;
    int guard = 0;
    rdata_busy = 0;
    while (got < NR && guard < 200) begin
      if (rdata_valid) begin
        if (got == stall_at) begin
          rdata_busy = 1;
          for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", rdata_valid, 1);
            chk("stall_data", rdata, exp[32*got +: 32]);
          end
          rdata_busy = 0;
        end
        chk("rdata", rdata, exp[32*got +: 32]);
        chk("rdata_last", rdata_last, (got == NR-1));
        got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (got < NR) chk("drain_timeout", got, NR);
    chk("post_drain_valid", rdata_valid, 0);
  endtask

  task automatic watch_no_valid(input string nm, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      if (rdata_valid) seen++;
      @(posedge clk); #1;
    end
    chk(nm, seen, 0);
  endtask

  task automatic compute_job(input vec_t v, input int stall_at);
    apb_wr(AddrCtrl, 32'h3);
    chk("compute_mode", work_mode, 2);
    for (int c = 0; c < NC; c++) send(v.x[8*c +: 8], c == NC-1);
    latency_chk();
    collect(v.exp, stall_at);
    exp_cnt++;
    rd_chk("job_status_done", AddrStatus, 32'h2);
    rd_chk("job_cnt", AddrCnt, exp_cnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_rdata_last"}, rdata_last, 0);
    chk({tag, "_wdata_busy"}, wdata_busy, 1);
    chk({tag, "_pe_busy"}, pe_busy, 0);
    chk({tag, "_work_mode"}, work_mode, 0);
    chk({tag, "_prdata"}, prdata, 0);
  endtask

  initial begin
    // Directed vectors with hand-derived results, then random ones scored by the model.
    for (int i = 0; i < 16; i++) begin
      tbl[0].wt[8*i +: 8] = 8'((i / 4) + 1);
      tbl[1].wt[8*i +: 8] = 8'h80;
      tbl[2].wt[8*i +: 8] = ((i / 4) == (i % 4)) ? 8'h01 : 8'h00;
      tbl[3].wt[8*i +: 8] = 8'h7F;
      tbl[4].wt[8*i +: 8] = 8'h80;
    end
    tbl[0].x = 32'h04030201; tbl[0].exp = {32'd40, 32'd30, 32'd20, 32'd10};
    tbl[1].x = 32'h80808080;
    tbl[2].x = 32'hF807FA05;
    tbl[2].exp = {32'hFFFFFFF8, 32'h00000007, 32'hFFFFFFFA, 32'h00000005};
    tbl[3].x = 32'h7F7F7F7F;
    tbl[4].x = 32'h7F7F7F7F;
`ifdef PE_SAT_EN
    tbl[1].exp = {4{32'h00007FFF}};
    tbl[3].exp = {4{32'h00007FFF}};
    tbl[4].exp = {4{32'hFFFF8000}};
`else
    tbl[1].exp = {4{32'h00000000}};
    tbl[3].exp = {4{32'hFFFFFC04}};
    tbl[4].exp = {4{32'h00000200}};
`endif
    for (int j = 5; j < 10; j++) begin
      tbl[j].wt  = {$urandom, $urandom, $urandom, $urandom};
      tbl[j].x   = $urandom;
      tbl[j].exp = model(tbl[j].wt, tbl[j].x);
    end

    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    wdata = 0; wdata_valid = 0; wdata_last = 0; rdata_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("pready", pready, 1);
    rst = 0;
    @(posedge clk); #1;
    rd_chk("id", AddrId, 32'hA5);
    rd_chk("status_reset", AddrStatus, 0);
    rd_chk("cnt_reset", AddrCnt, 0);
    apb_wr(8'h20, 32'h3);
    chk("unmapped_write_ignored", work_mode, 0);
    rd_chk("unmapped_read", 8'h10, 0);

    for (int j = 0; j < 10; j++) begin
      load_weights(tbl[j].wt);
      compute_job(tbl[j], (j == 0) ? 1 : -1);
    end

    // Early wdata_last abandons the compute job.
    apb_wr(AddrCtrl, 32'h3);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    chk("early_last_idle", work_mode, 0);
    watch_no_valid("early_last_no_output", 8);
    rd_chk("early_last_err", AddrStatus, 32'h4);
    rd_chk("early_last_cleared", AddrStatus, 0);
    rd_chk("early_last_cnt", AddrCnt, exp_cnt);

    // Start written mid-COMPUTE is ignored but flagged.
    load_weights(tbl[0].wt);
    apb_wr(AddrCtrl, 32'h3);
    send(tbl[0].x[7:0], 1'b0);
    send(tbl[0].x[15:8], 1'b0);
    apb_wr(AddrCtrl, 32'h3);
    chk("restart_ignored_mode", work_mode, 2);
    send(tbl[0].x[23:16], 1'b0);
    send(tbl[0].x[31:24], 1'b1);
    latency_chk();
    collect(tbl[0].exp, -1);
    exp_cnt++;
    rd_chk("restart_status", AddrStatus, 32'h6);
    rd_chk("restart_cnt", AddrCnt, exp_cnt);

    // Reset during DRAIN after one result has been taken.
    apb_wr(AddrCtrl, 32'h3);
    for (int c = 0; c < NC; c++) send(tbl[0].x[8*c +: 8], c == NC-1);
    latency_chk();
    @(posedge clk); #1;
    chk("drain_second_result", rdata, 32'd20);
    rst = 1;
    #1;
    chk_reset_outputs("mid_drain_rst");
    @(posedge clk); #1;
    rst = 0;
    exp_cnt = 0;
    watch_no_valid("post_rst_no_output", 10);
    rd_chk("post_rst_id", AddrId, 32'hA5);
    rd_chk("post_rst_status", AddrStatus, 0);
    rd_chk("post_rst_cnt", AddrCnt, 0);
    compute_job('{wt: '0, x: tbl[0].x, exp: '0}, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_cell.md
PE_MAC_CELL -- requirements
Module: pe_mac_cell

Interface
REQ-001 Parameters (name, default, meaning): WID_X 8, input element width; WID_Y 8, weight width; ROW 4, output rows; COL 4, input columns; WID_BUS 32, stream bus width; WID_ACC 24, accumulator width.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 pe_id  in  8  cell identifier, readable over APB.
REQ-005 psel, penable, pwrite  in  1 each  APB control; paddr  in  8; pwdata  in  32.
REQ-006 prdata  out  32  APB read data; pready  out  1  APB ready.
REQ-007 wdata  in  WID_BUS  stream element, low bits significant; wdata_valid, wdata_last  in  1; wdata_busy  out  1.
REQ-008 rdata  out  WID_BUS  result, sign-extended WID_ACC; rdata_valid, rdata_last  out  1; rdata_busy  in  1.
REQ-009 pe_busy  out  1  high when state is not IDLE; work_mode  out  2  current state code.

Function
REQ-010 pready SHALL be constant 1 (zero wait); the register acts on psel&penable.
REQ-011 Registers: 0x00 CTRL (W: bit0 start self-clearing, bit1 mode 0=load 1=compute); 0x04 STATUS (R: bit0 busy, bit1 done, bit2 err; done/err clear on read); 0x08 ID (R: pe_id); 0x0C CNT (R: completed compute jobs, 16-bit, wraps).
REQ-012 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-013 FSM states IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3: IDLE->LOAD on start with mode 0, IDLE->COMPUTE on start with mode 1.
REQ-014 A start written outside IDLE SHALL be ignored and SHALL set err.
REQ-015 Transfer occurs when wdata_valid=1 and wdata_busy=0; wdata_busy SHALL be 0 only in LOAD and COMPUTE.
REQ-016 LOAD SHALL accept ROW*COL weights in row-major order, w[r][c] = wdata[WID_Y-1:0] signed; on the final element it goes to IDLE and sets done.
REQ-017 COMPUTE SHALL accept COL elements x[c] = wdata[WID_X-1:0] signed; each accepted x[c] adds w[r][c]*x[c] to acc[r] for all r in parallel; acc SHALL be cleared on COMPUTE entry.
REQ-018 Products SHALL be registered in one pipeline stage; after the final x handshake the FSM enters DRAIN, with first rdata_valid exactly 2 cycles after that handshake.
REQ-019 DRAIN SHALL output acc[0]..acc[ROW-1] in order; rdata_last=1 with acc[ROW-1]; rdata/rdata_valid/rdata_last SHALL hold stable while rdata_busy=1.
REQ-020 After the final output handshake the FSM SHALL go to IDLE, set done and increment CNT.
REQ-021 wdata_last before the final element SHALL set err, discard the partial job and return to IDLE; a final element without wdata_last SHALL be accepted normally and SHALL set err.
REQ-022 Products are WID_X+WID_Y signed bits, sign-extended to WID_ACC before accumulation.

Reset
REQ-023 rst SHALL force IDLE, acc and all weights 0, STATUS 0, CNT 0, prdata 0, rdata 0, rdata_valid 0, rdata_last 0, wdata_busy 1, pe_busy 0, work_mode 0.
REQ-024 rst asserted mid-LOAD, mid-COMPUTE or mid-DRAIN SHALL abandon the job with no partial output after release.

Configuration
REQ-025 With PE_SAT_EN defined, accumulation SHALL saturate to the signed WID_ACC max/min; without it, accumulation SHALL wrap modulo 2^WID_ACC.

Structure
REQ-026 Package pe_mac_pkg SHALL hold the state enum, mode enum, register address constants and STATUS bit positions.
REQ-027 APB decode and registers SHALL be the sub-module pe_apb_regs; the FSM, weight store and MAC datapath stay in pe_mac_cell.

Verification
REQ-028 Load w[r][c]=r+1 for all c, compute with x=1,2,3,4 -> rdata 10,20,30,40, last on 40, done=1, CNT=1.
REQ-029 Load w=-128 in all slots, compute with x=-128 in all COL columns, WID_ACC=16 -> with PE_SAT_EN outputs 32767; without it, wrapped value 0 (4*16384 mod 2^16).
REQ-030 Hold rdata_busy=1 for 5 cycles on the second result -> rdata stable at acc[1] throughout, no loss or duplication.
REQ-031 wdata_last on the 2nd of 4 compute elements -> err=1, IDLE, no rdata_valid; STATUS read returns err, then reads 0.
REQ-032 Write CTRL start during COMPUTE -> ignored, err=1, job completes with correct results.
REQ-033 Assert rst during DRAIN after one output -> all outputs at reset values, IDLE, no further rdata_valid; read of ID returns pe_id.
